vector_lsu: RTL and testbench

- Initiator-side vector load/store unit that drives the 16-lane × 16-bit data memory port: address, write-enable, 256-bit write data and combinational 256-bit read data.
- Accepts one vector memory request at a time from the execute stage.
- Unit-stride requests complete in a single memory beat. Strided requests are sequenced element by element; strided stores use per-element read-modify-write.
- Returns load data in register lane order and pulses a completion strobe.

---
 rtl/vector_lsu_if.sv | 27 ++
 rtl/vector_lsu.sv | 142 ++++++++++++++
 tb/tb_vector_lsu.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vector_lsu_if.sv
// rtl/vector_lsu_if.sv - request/response and data-memory port bundle for vector_lsu
interface vector_lsu_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_store;
    logic         req_strided;
    logic [15:0]  req_base;
    logic [15:0]  req_stride;
    logic [255:0] req_wdata;
    logic         resp_valid;
    logic [255:0] resp_rdata;
    logic         busy;
    logic [15:0]  mem_a;
    logic         mem_we;
    logic [255:0] mem_wd;
    logic [255:0] mem_rd;

    modport slave (
        input  req_valid, req_store, req_strided, req_base, req_stride, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, busy, mem_a, mem_we, mem_wd
    );

    modport master (
        output req_valid, req_store, req_strided, req_base, req_stride, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, busy, mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/vector_lsu.sv
// rtl/vector_lsu.sv - vector load/store unit, unit-stride single beat, strided element sequencing
module vector_lsu #(
    parameter int LANES = 16,
    parameter int EW    = 16,
    parameter int AW    = 16
) (
    input  logic           clk,
    input  logic           rst,
    vector_lsu_if.slave    bus
);
    localparam int DW = LANES * EW;

    typedef enum logic [2:0] {IDLE, UACC, SLD, SRD, SWR, DONE} state_t;

    state_t        state_q, state_d;
    logic          store_q, store_d;
    logic          strided_q, strided_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    idx_q, idx_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] rmw_q, rmw_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [AW-1:0] elem_addr;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic          resp_valid;

    // Element address wraps mod 2^AW; the product is truncated to AW bits.
    assign elem_addr = base_q + ({{(AW-4){1'b0}}, idx_q} * stride_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            store_q   <= 1'b0;
            strided_q <= 1'b0;
            base_q    <= '0;
            stride_q  <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            rmw_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            store_q   <= store_d;
            strided_q <= strided_d;
            base_q    <= base_d;
            stride_q  <= stride_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            rmw_q     <= rmw_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        strided_d  = strided_q;
        base_d     = base_q;
        stride_d   = stride_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        rmw_d      = rmw_q;
        rdata_d    = rdata_q;
        mem_a      = '0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    store_d   = bus.req_store;
                    strided_d = bus.req_strided;
                    base_d    = bus.req_base;
                    stride_d  = bus.req_stride;
                    wdata_d   = bus.req_wdata;
                    idx_d     = '0;
                    if (!bus.req_strided)  state_d = UACC;
                    else if (bus.req_store) state_d = SRD;
                    else                    state_d = SLD;
                end
            end
            UACC: begin
                mem_a = base_q;
                if (store_q) begin
                    mem_we = 1'b1;
                    mem_wd = wdata_q;
                end else begin
                    // Memory presents element 0 in the MSB word; lanes are LSB-first.
                    for (int i = 0; i < LANES; i++)
                        rdata_d[i*EW +: EW] = bus.mem_rd[DW-1-i*EW -: EW];
                end
                state_d = DONE;
            end
            SLD: begin
                mem_a = elem_addr;
                shadow_d[int'(idx_q)*EW +: EW] = bus.mem_rd[DW-1 -: EW];
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    rdata_d = shadow_d;
                    state_d = DONE;
                end
            end
            SRD: begin
                mem_a   = elem_addr;
                rmw_d   = bus.mem_rd;
                state_d = SWR;
            end
            SWR: begin
                mem_a  = elem_addr;
                mem_we = 1'b1;
                // The port writes a full 16-word beat; neighbours are restored from the fresh read.
                for (int k = 1; k < LANES; k++)
                    mem_wd[k*EW +: EW] = rmw_q[DW-1-k*EW -: EW];
                mem_wd[EW-1:0] = wdata_q[int'(idx_q)*EW +: EW];
                idx_d = idx_q + 4'd1;
                state_d = (idx_q == 4'd15) ? DONE : SRD;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_a      = mem_a;
    assign bus.mem_we     = mem_we;
    assign bus.mem_wd     = mem_wd;
endmodule

// File: tb/tb_vector_lsu.sv
// tb/tb_vector_lsu.sv - scoreboard bench for vector_lsu with a 1K-word behavioural memory
module tb_vector_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    vector_lsu_if bus();
    vector_lsu dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_a  = '0;
    logic [15:0] pre_d  = '0;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0;
        end else if (bus.mem_we) begin
            for (int k = 0; k < 16; k++) mem[10'(bus.mem_a + 16'(k))] <= bus.mem_wd[16*k +: 16];
        end else if (pre_en) begin
            mem[pre_a] <= pre_d;
        end
    end

    always_comb begin
        bus.mem_rd = '0;
        for (int k = 0; k < 16; k++) bus.mem_rd[255-16*k -: 16] = mem[10'(bus.mem_a + 16'(k))];
    end

    typedef struct {
        bit           load;
        logic [255:0] rdata;
        int           due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [16:0] trace[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          we_cnt = 0;
    int          resp_cnt = 0;
    logic [255:0] last_wd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy) trace.push_back({bus.mem_we, bus.mem_a});
            if (bus.mem_we) begin
                we_cnt++;
                last_wd = bus.mem_wd;
            end
            if (bus.resp_valid) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_resp: got resp_valid at cycle %0d with empty scoreboard", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("resp_cycle", 256'(cyc), 256'(e.due));
                    if (e.load) chk("resp_rdata", bus.resp_rdata, e.rdata);
                end
            end
        end
    end

    task automatic pre(input logic [9:0] a, input logic [15:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_en = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic issue(input bit st, input bit sd, input logic [15:0] base, input logic [15:0] stride,
                         input logic [255:0] wd, input bit push, input logic [255:0] exp_rd, input int lat);
        int n = 0;
        exp_t x;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 100) chk("req_ready_timeout", 256'(bus.req_ready), 256'd1);
        trace.delete();
        we_cnt = 0;
        bus.req_store   = st;
        bus.req_strided = sd;
        bus.req_base    = base;
        bus.req_stride  = stride;
        bus.req_wdata   = wd;
        bus.req_valid   = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        if (push) begin
            x.load  = !st;
            x.rdata = exp_rd;
            x.due   = cyc + lat - 1;
            sb.push_back(x);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("busy_timeout", 256'(bus.busy), 256'd0);
    endtask

    logic [255:0] wd, exp_v, act_v;
    logic [15:0]  a16;
    int           rc;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_store = 1'b0;
        bus.req_strided = 1'b0;
        bus.req_base = '0;
        bus.req_stride = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clr = 1'b0;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle_ctl", 256'({bus.req_ready, bus.busy, bus.mem_we, bus.resp_valid}), 256'(4'b1000));
            chk("idle_rdata_addr", {bus.resp_rdata[239:0], bus.mem_a}, 256'd0);
        end

        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'h1000 + 16'(i);
        issue(1'b1, 1'b0, 16'h0020, 16'h0, wd, 1'b1, '0, 2);
        wait_idle();
        chk("ustore_we_cnt", 256'(we_cnt), 256'd1);
        chk("ustore_wd", last_wd, wd);
        for (int i = 0; i < 16; i++) act_v[16*i +: 16] = mem[10'h020 + 10'(i)];
        chk("ustore_mem", act_v, wd);

        issue(1'b0, 1'b0, 16'h0020, 16'h0, '0, 1'b1, wd, 2);
        wait_idle();
        chk("uload_we_cnt", 256'(we_cnt), 256'd0);

        for (int i = 0; i < 16; i++) pre(10'h100 + 10'(3*i), 16'hA000 + 16'(i));
        for (int i = 0; i < 16; i++) exp_v[16*i +: 16] = 16'hA000 + 16'(i);
        issue(1'b0, 1'b1, 16'h0100, 16'd3, '0, 1'b1, exp_v, 17);
        wait_idle();
        chk("sload_we_cnt", 256'(we_cnt), 256'd0);
        chk("sload_trace_len", 256'(trace.size()), 256'd17);
        for (int i = 0; i < 16; i++) begin
            exp_v[16*i +: 16] = 16'h0100 + 16'(3*i);
            act_v[16*i +: 16] = (trace.size() > i) ? trace[i][15:0] : 16'hxxxx;
        end
        chk("sload_addrs", act_v, exp_v);
        chk("sload_done_bus", 256'((trace.size() > 16) ? trace[16] : 17'h1ffff), 256'd0);

        for (int i = 0; i < 32; i++) pre(10'h200 + 10'(i), 16'hFFFF);
        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'(i);
        issue(1'b1, 1'b1, 16'h0200, 16'd1, wd, 1'b1, '0, 33);
        wait_idle();
        chk("sstore_we_cnt", 256'(we_cnt), 256'd16);
        for (int i = 0; i < 16; i++) act_v[16*i +: 16] = mem[10'h200 + 10'(i)];
        chk("sstore_mem_lo", act_v, wd);
        for (int i = 0; i < 16; i++) act_v[16*i +: 16] = mem[10'h210 + 10'(i)];
        chk("sstore_mem_hi", act_v, {256{1'b1}});

        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'h5000 + 16'(i);
        issue(1'b1, 1'b1, 16'h0300, 16'd0, wd, 1'b1, '0, 33);
        wait_idle();
        chk("stride0_store_word", 256'(mem[10'h300]), 256'h500F);
        chk("stride0_store_next", 256'(mem[10'h301]), 256'h0);
        issue(1'b0, 1'b1, 16'h0300, 16'd0, '0, 1'b1, {16{16'h500F}}, 17);
        wait_idle();

        pre(10'h3FE, 16'hBEE0);
        pre(10'h3FF, 16'hBEE1);
        for (int i = 0; i < 14; i++) pre(10'(i), 16'hBEE2 + 16'(i));
        for (int i = 0; i < 16; i++) exp_v[16*i +: 16] = 16'hBEE0 + 16'(i);
        issue(1'b0, 1'b1, 16'hFFFE, 16'd1, '0, 1'b1, exp_v, 17);
        wait_idle();
        for (int i = 0; i < 16; i++) begin
            a16 = 16'hFFFE + 16'(i);
            exp_v[16*i +: 16] = a16;
            act_v[16*i +: 16] = (trace.size() > i) ? trace[i][15:0] : 16'hxxxx;
        end
        chk("wrap_addrs", act_v, exp_v);

        for (int i = 0; i < 32; i++) pre(10'h400 + 10'(i), 16'h7777);
        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'h0E00 + 16'(i);
        issue(1'b1, 1'b1, 16'h0400, 16'd1, wd, 1'b0, '0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rc = resp_cnt;
        chk("rst_ctl", 256'({bus.req_ready, bus.busy, bus.mem_we}), 256'(3'b100));
        chk("rst_rdata", bus.resp_rdata, '0);
        repeat (5) @(negedge clk);
        chk("rst_no_resp", 256'(resp_cnt), 256'(rc));
        chk("rst_elem01", 256'({mem[10'h400], mem[10'h401]}), 256'({16'h0E00, 16'h0E01}));
        for (int i = 0; i < 16; i++) act_v[16*i +: 16] = mem[10'h402 + 10'(i)];
        chk("rst_untouched", act_v, {16{16'h7777}});

        chk("sb_drained", 256'(sb.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
